au_prefix_and_pipe: RTL and testbench
=====================================

Name: au_prefix_and_pipe

Overview:
- Registered prefix-AND ("group propagate") network for carry-prefix adders, incrementers and leading-ones logic.
- Each output bit i is the AND of input bits i down to 0.
- Prefix-network topology is selectable by parameter; function is identical for every topology.
- Result is registered once on a single clock, with a synchronous active-high reset.

Parameters:
- WIDTH, 8, word length of pi and po; legal range 1 to 64.
- ARCH, 0, prefix topology: 0 = Sklansky, 1 = Kogge-Stone, 2 = Brent-Kung, 3 = serial ripple. Any other value builds ARCH 0.

Ports:
- clk  input  1  single clock, all state on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- pi  input  WIDTH  propagate input data, sampled every rising edge (no valid qualifier).
- po  output  WIDTH  registered prefix-AND result.

Behaviour:
- Function: po[i] = pi[0] & pi[1] & ... & pi[i], for i = 0..WIDTH-1.
  - po[0] = pi[0].
  - po[WIDTH-1] = reduction AND of all of pi.
- Monotonic: once a 0 appears in po at bit k, every po bit above k is 0. po is always of the form 0...01...1.
- Timing:
  - pi feeds the combinational prefix network directly (no input register).
  - The network output is captured in a WIDTH-bit register on the rising edge of clk.
  - Latency is exactly 1 cycle: po after edge n equals f(pi sampled at edge n).
  - Throughput is one word per cycle.
- Reset:
  - rst high at a rising edge loads po = all zeros, regardless of pi.
  - Reset takes priority over capture.
  - rst has no asynchronous effect.
  - The first edge after rst deasserts captures f(pi) normally.
  - A reset asserted mid-stream discards the in-flight result. po reads 0 for each reset cycle, then resumes 1-cycle latency.
- Topologies (all use 2-input AND nodes only):
  - Sklansky: ceil(log2 WIDTH) levels, high fan-out.
  - Kogge-Stone: ceil(log2 WIDTH) levels, fan-out 2.
  - Brent-Kung: up-sweep plus down-sweep, about 2*log2 WIDTH levels.
  - Serial: WIDTH-1 chained ANDs.
- Non-power-of-2 WIDTH: build the network for the next power of 2 and drop unused columns. Equivalently, pad with 1s above the MSB and discard the padded outputs.
- WIDTH = 1: po = pi registered; no network.
- No X propagation beyond what the AND gates imply. Outputs must be 0/1 whenever the inputs are 0/1.

Decomposition:
- Shared package au_pkg:
  - localparams ARCH_SKLANSKY=0, ARCH_KOGGE_STONE=1, ARCH_BRENT_KUNG=2, ARCH_SERIAL=3.
  - Function clog2-based level count used by the generate loops.
- One sub-module au_prefix_and_net (parameters WIDTH, ARCH; ports pi, po):
  - purely combinational;
  - all topologies live in generate branches.
- The top module holds only the output register and reset mux.
- The same net is reusable by prefix adders.

Test Plan:
- Reset: assert rst for 2 cycles with pi=8'hFF -> po=8'h00 on both cycles. Release with pi=8'hFF -> po=8'hFF one cycle later.
- Corner words (WIDTH=8), each checked 1 cycle after applying:
  - pi=8'h00 -> 8'h00
  - pi=8'hFF -> 8'hFF
  - pi=8'h0F -> 8'h0F
  - pi=8'hF7 -> 8'h07
  - pi=8'hFE -> 8'h00
  - pi=8'h7F -> 8'h7F
- Back-to-back pipelining: stream pi=8'h01, 8'h03, 8'hFB, 8'hFF on consecutive cycles -> po=8'h01, 8'h03, 8'h03, 8'hFF on the following consecutive cycles.
- Mid-stream reset: stream 8'hFF, 8'h3F with rst high on the 8'h3F edge -> po=8'hFF then 8'h00. Next pi=8'h3F -> 8'h3F.
- Exhaustive sweep, for every ARCH 0-3 at WIDTH=8 and WIDTH=13: all 2^WIDTH inputs compared against a behavioural model (running AND from bit 0) -> zero mismatches, checked 1 cycle after each input.
- Random sweep:
  - WIDTH=32 and WIDTH=64, every ARCH: 10000 random words plus all-zeros and all-ones -> zero mismatches against the behavioural model.
  - WIDTH=1: pi=0 gives po=0, pi=1 gives po=1.

Source files
------------

// File: rtl/au_pkg.sv
// rtl/au_pkg.sv - shared topology selectors and level-count helper for prefix-AND networks
// Purpose: constants and helpers shared by the prefix-AND net and its wrappers.
// Ports: none (package).
package au_pkg;

  localparam int ARCH_SKLANSKY    = 0;
  localparam int ARCH_KOGGE_STONE = 1;
  localparam int ARCH_BRENT_KUNG  = 2;
  localparam int ARCH_SERIAL      = 3;

  // Number of log-depth levels needed to span a word of the given width.
  function automatic int au_levels(input int width);
    return (width <= 1) ? 0 : $clog2(width);
  endfunction

endpackage

// File: rtl/au_prefix_and_pipe_if.sv
// rtl/au_prefix_and_pipe_if.sv - data bundle between a prefix-AND pipe and its user
// Purpose: groups the propagate input word and the registered prefix result.
// Ports: pi (propagate word into the pipe), po (registered prefix-AND result).
//   master: drives pi, reads po.  slave: reads pi, drives po.
interface au_prefix_and_pipe_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] pi;
  logic [WIDTH-1:0] po;

  modport master (output pi, input po);
  modport slave  (input pi, output po);

endinterface

// File: rtl/au_prefix_and_net.sv
// rtl/au_prefix_and_net.sv - combinational prefix-AND network, topology chosen by ARCH
// Purpose: po[i] = &pi[i:0], built from 2-input ANDs in the selected topology.
// Ports: pi (WIDTH, input word), po (WIDTH, prefix-AND of pi).
// Non power-of-two widths simply omit the columns at and above WIDTH; prefix
// terms only flow upward, so the omitted columns never feed a kept one.
module au_prefix_and_net
  import au_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] pi,
  output logic [WIDTH-1:0] po
);

  localparam int L   = au_levels(WIDTH);
  localparam int SEL = (ARCH == ARCH_KOGGE_STONE || ARCH == ARCH_BRENT_KUNG ||
                        ARCH == ARCH_SERIAL) ? ARCH : ARCH_SKLANSKY;

  // Scalar unpacked arrays keep each node a separate net, so the chains are
  // not seen as a vector feeding back into itself.
  if (WIDTH == 1) begin : g_single
    assign po = pi;
  end else if (SEL == ARCH_SERIAL) begin : g_serial
    logic chain [WIDTH];
    assign chain[0] = pi[0];
    assign po[0]    = chain[0];
    for (genvar i = 1; i < WIDTH; i++) begin : g_bit
      assign chain[i] = chain[i-1] & pi[i];
      assign po[i]    = chain[i];
    end
  end else if (SEL == ARCH_KOGGE_STONE) begin : g_ks
    logic lvl [0:L][WIDTH];
    for (genvar i = 0; i < WIDTH; i++) begin : g_in
      assign lvl[0][i] = pi[i];
      assign po[i]     = lvl[L][i];
    end
    for (genvar l = 0; l < L; l++) begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= (1 << l)) begin : g_and
          assign lvl[l+1][i] = lvl[l][i] & lvl[l][i-(1<<l)];
        end else begin : g_pass
          assign lvl[l+1][i] = lvl[l][i];
        end
      end
    end
  end else if (SEL == ARCH_BRENT_KUNG) begin : g_bk
    logic up [0:L][WIDTH];
    logic dn [0:L-1][WIDTH];
    for (genvar i = 0; i < WIDTH; i++) begin : g_in
      assign up[0][i] = pi[i];
      assign dn[0][i] = up[L][i];
      assign po[i]    = dn[L-1][i];
    end
    // Up-sweep: the last column of each 2^(l+1) block absorbs its lower half.
    for (genvar l = 0; l < L; l++) begin : g_up
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % (1 << (l + 1))) == 0) begin : g_and
          assign up[l+1][i] = up[l][i] & up[l][i-(1<<l)];
        end else begin : g_pass
          assign up[l+1][i] = up[l][i];
        end
      end
    end
    // Down-sweep: mid-block columns pick up the full prefix just below them.
    for (genvar d = 0; d < L - 1; d++) begin : g_dn
      localparam int LV = L - 2 - d;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if ((((i + 1) % (1 << (LV + 1))) == (1 << LV)) && (i >= (1 << (LV + 1)))) begin : g_and
          assign dn[d+1][i] = dn[d][i] & dn[d][i-(1<<LV)];
        end else begin : g_pass
          assign dn[d+1][i] = dn[d][i];
        end
      end
    end
  end else begin : g_sk
    logic lvl [0:L][WIDTH];
    for (genvar i = 0; i < WIDTH; i++) begin : g_in
      assign lvl[0][i] = pi[i];
      assign po[i]     = lvl[L][i];
    end
    // Upper half of each 2^(l+1) block takes the top column of the lower half.
    for (genvar l = 0; l < L; l++) begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i >> l) & 1) == 1) begin : g_and
          assign lvl[l+1][i] = lvl[l][i] & lvl[l][((i >> (l + 1)) << (l + 1)) + (1 << l) - 1];
        end else begin : g_pass
          assign lvl[l+1][i] = lvl[l][i];
        end
      end
    end
  end

endmodule

// File: rtl/au_prefix_and_pipe.sv
// rtl/au_prefix_and_pipe.sv - prefix-AND network with a single registered output stage
// Purpose: po = registered prefix-AND of pi, one cycle latency, one word per cycle.
// Ports: clk (rising-edge clock), rst (synchronous active-high reset, clears po),
//   bus.pi (WIDTH, propagate word, sampled every edge), bus.po (WIDTH, result).
module au_prefix_and_pipe
  import au_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ARCH  = ARCH_SKLANSKY
) (
  input  logic                  clk,
  input  logic                  rst,
  au_prefix_and_pipe_if.slave   bus
);

  logic [WIDTH-1:0] net_po;

  au_prefix_and_net #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_net (
    .pi (bus.pi),
    .po (net_po)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.po <= '0;
    end else begin
      bus.po <= net_po;
    end
  end

endmodule

// File: tb/tb_au_prefix_and_pipe.sv
// tb/tb_au_prefix_and_pipe.sv - scoreboard bench over several widths and topologies
module tb_au_prefix_and_pipe;

  localparam int N = 18;

  function automatic int cfg_w(input int g);
    if (g < 4)   return 8;
    if (g < 8)   return 13;
    if (g < 12)  return 32;
    if (g < 16)  return 64;
    if (g == 16) return 1;
    return 8;
  endfunction

  function automatic int cfg_a(input int g);
    if (g < 16)  return g % 4;
    if (g == 16) return 0;
    return 7;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] v, input int w);
    logic        run;
    logic [63:0] r;
    run = 1'b1;
    r   = '0;
    for (int i = 0; i < w; i++) begin
      run  = run & v[i];
      r[i] = run;
    end
    return r;
  endfunction

  typedef struct {
    logic [63:0] stim;
    logic        rst;
    bit          has_exp;
    logic [7:0]  exp8;
    logic [95:0] tag;
  } entry_t;

  logic        clk;
  logic        rst;
  logic [63:0] stim;
  logic [63:0] po_all [N];
  entry_t      q [$];
  int          tests;
  int          fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = cfg_w(g);
    localparam int A = cfg_a(g);
    au_prefix_and_pipe_if #(.WIDTH(W)) ifc ();
    assign ifc.pi = stim[W-1:0];
    au_prefix_and_pipe #(.WIDTH(W), .ARCH(A)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );
    if (W < 64) begin : g_pad
      assign po_all[g] = {{(64 - W){1'b0}}, ifc.po};
    end else begin : g_full
      assign po_all[g] = ifc.po;
    end
  end

  task automatic drive(input logic [63:0] v, input logic r, input bit he,
                       input logic [7:0] e, input logic [95:0] tag);
    entry_t en;
    @(negedge clk);
    stim = v;
    rst  = r;
    en.stim = v; en.rst = r; en.has_exp = he; en.exp8 = e; en.tag = tag;
    q.push_back(en);
  endtask

  task automatic dir8(input logic [7:0] v, input logic r, input logic [7:0] e,
                      input logic [95:0] tag);
    drive({56'h0, v}, r, 1'b1, e, tag);
  endtask

  // Monitor: one result per cycle, compared just after the capturing edge.
  initial begin
    entry_t      e;
    logic [63:0] exp;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.has_exp) begin
          tests++;
          if (po_all[0][7:0] !== e.exp8) begin
            fails++;
            $display("FAIL %s pi=%h got=%h want=%h", e.tag, e.stim[7:0], po_all[0][7:0], e.exp8);
          end
        end
        for (int g = 0; g < N; g++) begin
          exp = e.rst ? 64'h0 : model(e.stim, cfg_w(g));
          tests++;
          if (po_all[g] !== exp) begin
            fails++;
            $display("FAIL model cfg%0d w=%0d arch=%0d pi=%h got=%h want=%h",
                     g, cfg_w(g), cfg_a(g), e.stim, po_all[g], exp);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] r64;
    logic [63:0] mask;
    int          k;
    tests = 0;
    fails = 0;
    stim  = 64'h0;
    rst   = 1'b1;

    dir8(8'hFF, 1'b1, 8'h00, "reset1");
    dir8(8'hFF, 1'b1, 8'h00, "reset2");
    dir8(8'hFF, 1'b0, 8'hFF, "release");

    dir8(8'h00, 1'b0, 8'h00, "corner00");
    dir8(8'hFF, 1'b0, 8'hFF, "cornerFF");
    dir8(8'h0F, 1'b0, 8'h0F, "corner0F");
    dir8(8'hF7, 1'b0, 8'h07, "cornerF7");
    dir8(8'hFE, 1'b0, 8'h00, "cornerFE");
    dir8(8'h7F, 1'b0, 8'h7F, "corner7F");

    dir8(8'h01, 1'b0, 8'h01, "pipe01");
    dir8(8'h03, 1'b0, 8'h03, "pipe03");
    dir8(8'hFB, 1'b0, 8'h03, "pipeFB");
    dir8(8'hFF, 1'b0, 8'hFF, "pipeFF");

    dir8(8'hFF, 1'b0, 8'hFF, "midFF");
    dir8(8'h3F, 1'b1, 8'h00, "midrst");
    dir8(8'h3F, 1'b0, 8'h3F, "mid3F");

    drive(64'h0, 1'b0, 1'b0, 8'h0, "zeros64");
    drive({64{1'b1}}, 1'b0, 1'b0, 8'h0, "ones64");

    for (int i = 0; i < 8192; i++) begin
      drive(64'(i), 1'b0, 1'b0, 8'h0, "sweep");
    end

    for (int i = 0; i < 10000; i++) begin
      r64  = {$urandom, $urandom};
      k    = $urandom_range(0, 64);
      mask = (k == 64) ? {64{1'b1}} : ((64'h1 << k) - 64'h1);
      drive((i % 2 == 1) ? r64 : (r64 | mask), 1'b0, 1'b0, 8'h0, "random");
    end

    repeat (3) @(posedge clk);
    #5;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d want=0 pending results", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
